// File: rtl/config_chain_sequencer.sv
// Command-FIFO driven sequencer for N_CHAINS serial config chains with a readback FIFO.
// Defining CFG_SEQ_LOOPBACK_EN adds loopback_en: capture from ConfigIn and keep ConfigClk at 0.
module config_chain_sequencer #(
   parameter int N_CHAINS   = 4,
   parameter int CMD_DEPTH  = 16,
   parameter int RDBK_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESET,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [31:0]          cmd_data,
   input  logic [DIV_WIDTH-1:0] clk_div,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [31:0]          rd_data,
   output logic                 busy,
   output logic                 err,
   input  logic                 err_clr,
`ifdef CFG_SEQ_LOOPBACK_EN
   input  logic                 loopback_en,
`endif
   output logic                 SuperpixSel,
   output logic [N_CHAINS-1:0]  ConfigClk,
   output logic [N_CHAINS-1:0]  ConfigIn,
   output logic [N_CHAINS-1:0]  ConfigLoad,
   output logic [N_CHAINS-1:0]  Reset_not,
   input  logic [N_CHAINS-1:0]  ConfigOut
);
   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RDBK_DEPTH);
   localparam int TW  = DIV_WIDTH + 17;
   localparam logic [CAW:0] CMD_FULL  = (CAW+1)'(CMD_DEPTH);
   localparam logic [RAW:0] RDBK_FULL = (RAW+1)'(RDBK_DEPTH);
   localparam logic [3:0] OP_RESET = 4'd1, OP_SHIFT = 4'd2, OP_WAIT = 4'd3, OP_LOAD = 4'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_RST_LO, S_SH_LO, S_SH_HI, S_WAIT, S_LOAD, S_PUSH
   } state_t;

   state_t                state_q;
   logic [31:0]           cmd_q;
   logic [N_CHAINS-1:0]   sel_q, sel_d;
   logic [DIV_WIDTH-1:0]  h_q, h_now;
   logic [TW-1:0]         tmr_q;
   logic [3:0]            bit_q;
   logic [15:0]           cap_q;
   logic [N_CHAINS-1:0]   clk_q, in_q, load_q, rstn_q;
   logic                  spx_q, err_q;

   // ---------------- command FIFO ----------------
   logic [31:0]    cmd_mem [CMD_DEPTH];
   logic [CAW-1:0] cmd_wp_q, cmd_rp_q;
   logic [CAW:0]   cmd_cnt_q, cmd_cnt_d;
   logic           cmd_rdy_q, cmd_push, cmd_pop;

   assign cmd_ready = cmd_rdy_q & ~S_AXI_ARESET;
   assign cmd_push  = cmd_valid & cmd_ready;
   assign cmd_pop   = (state_q == S_IDLE) && (cmd_cnt_q != '0);

   always_comb begin
      cmd_cnt_d = cmd_cnt_q;
      if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + (CAW+1)'(1);
      else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - (CAW+1)'(1);
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         cmd_wp_q  <= '0;
         cmd_rp_q  <= '0;
         cmd_cnt_q <= '0;
         cmd_rdy_q <= 1'b1;
      end else begin
         if (cmd_push) cmd_wp_q <= cmd_wp_q + CAW'(1);
         if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CAW'(1);
         cmd_cnt_q <= cmd_cnt_d;
         cmd_rdy_q <= (cmd_cnt_d != CMD_FULL);
      end
   end

   always_ff @(posedge S_AXI_ACLK)
      if (cmd_push) cmd_mem[cmd_wp_q] <= cmd_data;

   // ---------------- readback FIFO ----------------
   logic [31:0]    rb_mem [RDBK_DEPTH];
   logic [RAW-1:0] rb_wp_q, rb_rp_q;
   logic [RAW:0]   rb_cnt_q;
   logic           rb_push, rb_pop, need_push;

   assign need_push = (cmd_q[3:0] == OP_SHIFT) && cmd_q[9];
   assign rb_push   = (state_q == S_PUSH) && need_push && (rb_cnt_q != RDBK_FULL);
   assign rb_pop    = rd_valid & rd_ready;
   assign rd_valid  = (rb_cnt_q != '0);
   assign rd_data   = rb_mem[rb_rp_q];

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rb_wp_q  <= '0;
         rb_rp_q  <= '0;
         rb_cnt_q <= '0;
      end else begin
         if (rb_push) rb_wp_q <= rb_wp_q + RAW'(1);
         if (rb_pop)  rb_rp_q <= rb_rp_q + RAW'(1);
         if (rb_push && !rb_pop)      rb_cnt_q <= rb_cnt_q + (RAW+1)'(1);
         else if (!rb_push && rb_pop) rb_cnt_q <= rb_cnt_q - (RAW+1)'(1);
      end
   end

   always_ff @(posedge S_AXI_ACLK)
      if (rb_push) rb_mem[rb_wp_q] <= {cap_q, cmd_q[15:0]};

   // ---------------- decode helpers ----------------
   logic [3:0]    op, last_bit;
   logic [15:0]   arg;
   logic          bad, lb, sample;
   logic [TW-1:0] h1_now, h2m1_now, wait_now, h1_q;

   assign op       = cmd_q[3:0];
   assign arg      = cmd_q[31:16];
   assign last_bit = cmd_q[14] ? 4'hF : cmd_q[13:10];
   assign bad      = !(op inside {OP_RESET, OP_SHIFT, OP_WAIT, OP_LOAD}) ||
                     (32'(cmd_q[7:4]) >= 32'(N_CHAINS));
   assign h_now    = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
   assign h1_now   = TW'(h_now) - TW'(1);
   assign h2m1_now = TW'({h_now, 1'b0}) - TW'(1);
   assign wait_now = TW'(arg) * TW'({h_now, 1'b0}) - TW'(1);
   assign h1_q     = TW'(h_q) - TW'(1);

   always_comb begin
      sel_d = '0;
      for (int i = 0; i < N_CHAINS; i++) sel_d[i] = (cmd_q[7:4] == i[3:0]);
   end

`ifdef CFG_SEQ_LOOPBACK_EN
   assign lb = loopback_en;
`else
   assign lb = 1'b0;
`endif
   assign sample = lb ? |(in_q & sel_q) : |(ConfigOut & sel_q);

   // ---------------- sequencer FSM ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         sel_q   <= '0;
         h_q     <= DIV_WIDTH'(1);
         tmr_q   <= '0;
         bit_q   <= '0;
         cap_q   <= '0;
         clk_q   <= '0;
         in_q    <= '0;
         load_q  <= '0;
         rstn_q  <= '1;
         spx_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (err_clr)                          err_q <= 1'b0;
         else if (state_q == S_DECODE && bad)  err_q <= 1'b1;

         case (state_q)
            S_IDLE: if (cmd_pop) begin
               cmd_q   <= cmd_mem[cmd_rp_q];
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               h_q   <= h_now;
               sel_q <= sel_d;
               cap_q <= '0;
               bit_q <= '0;
               if (bad) state_q <= S_IDLE;
               else begin
                  case (op)
                     OP_RESET: begin
                        spx_q   <= cmd_q[8];
                        rstn_q  <= ~sel_d;
                        tmr_q   <= h2m1_now;
                        state_q <= S_RST_LO;
                     end
                     OP_SHIFT: begin
                        clk_q   <= '0;
                        in_q    <= arg[0] ? sel_d : '0;
                        tmr_q   <= h1_now;
                        state_q <= S_SH_LO;
                     end
                     OP_WAIT: begin
                        tmr_q   <= wait_now;
                        state_q <= (arg == '0) ? S_PUSH : S_WAIT;
                     end
                     default: begin
                        load_q  <= sel_d;
                        tmr_q   <= h2m1_now;
                        state_q <= S_LOAD;
                     end
                  endcase
               end
            end
            S_RST_LO, S_LOAD, S_WAIT: begin
               if (tmr_q == '0) begin
                  rstn_q  <= '1;
                  load_q  <= '0;
                  state_q <= S_PUSH;
               end else tmr_q <= tmr_q - TW'(1);
            end
            S_SH_LO: begin
               if (tmr_q == '0) begin
                  clk_q   <= sel_q;
                  tmr_q   <= h1_q;
                  state_q <= S_SH_HI;
               end else tmr_q <= tmr_q - TW'(1);
            end
            S_SH_HI: begin
               if (tmr_q == '0) begin
                  cap_q[bit_q] <= sample;
                  clk_q        <= '0;
                  if (bit_q == last_bit) begin
                     in_q    <= '0;
                     state_q <= S_PUSH;
                  end else begin
                     bit_q   <= bit_q + 4'd1;
                     in_q    <= arg[bit_q + 4'd1] ? sel_q : '0;
                     tmr_q   <= h1_q;
                     state_q <= S_SH_LO;
                  end
               end else tmr_q <= tmr_q - TW'(1);
            end
            S_PUSH: if (!need_push || rb_cnt_q != RDBK_FULL) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ConfigClk   = lb ? '0 : clk_q;
   assign ConfigIn    = in_q;
   assign ConfigLoad  = load_q;
   assign Reset_not   = rstn_q;
   assign SuperpixSel = spx_q;
   assign err         = err_q;
   assign busy        = (state_q != S_IDLE) || (cmd_cnt_q != '0);

endmodule

// File: tb/tb_config_chain_sequencer.sv
// Scoreboard bench for config_chain_sequencer: chains loop ConfigIn back to ConfigOut one cycle late.
`timescale 1ns/1ps
module tb_config_chain_sequencer;
   localparam int NC = 4;

   logic          clk = 1'b0, rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [31:0]   cmd_data = '0;
   logic [15:0]   clk_div = 16'd2;
   logic          rd_valid, rd_ready = 1'b0;
   logic [31:0]   rd_data;
   logic          busy, err, err_clr = 1'b0, spx;
   logic [NC-1:0] cclk, cin, cload, crstn, cout = '0;

   config_chain_sequencer #(.N_CHAINS(NC), .CMD_DEPTH(16), .RDBK_DEPTH(16), .DIV_WIDTH(16)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .clk_div(clk_div),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .err(err), .err_clr(err_clr),
`ifdef CFG_SEQ_LOOPBACK_EN
      .loopback_en(1'b0),
`endif
      .SuperpixSel(spx), .ConfigClk(cclk), .ConfigIn(cin), .ConfigLoad(cload),
      .Reset_not(crstn), .ConfigOut(cout));

   always #5 clk = ~clk;

   // chip model: each chain returns its serial input one ACLK later
   always @(posedge clk) cout <= cin;

   int clk_hi[NC] = '{default: 0}, clk_pul[NC] = '{default: 0}, in_hi[NC] = '{default: 0};
   int ld_hi[NC] = '{default: 0}, rst_lo[NC] = '{default: 0}, act = 0;
   int b_clk_hi[NC], b_clk_pul[NC], b_in_hi[NC], b_ld_hi[NC], b_rst_lo[NC], b_act;
   logic [NC-1:0] clk_prev = '0;

   always @(negedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (cclk[i]) clk_hi[i]++;
         if (cclk[i] && !clk_prev[i]) clk_pul[i]++;
         if (cin[i]) in_hi[i]++;
         if (cload[i]) ld_hi[i]++;
         if (!crstn[i]) rst_lo[i]++;
      end
      if ((|cclk) || (|cin) || (|cload) || !(&crstn)) act++;
      clk_prev <= cclk;
   end

   int n_vec = 0, n_err = 0;
   logic [31:0] q_exp[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] mk_shift(input logic [3:0] ch, input logic [4:0] cnt,
                                            input logic cap, input logic [15:0] a);
      return {a, 1'b0, cnt, cap, 1'b0, ch, 4'h2};
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] c);
      int nb;
      logic [15:0] m;
      nb = int'(c[14:10]) + 1;
      if (nb > 16) nb = 16;
      m = (nb == 16) ? 16'hFFFF : 16'((32'd1 << nb) - 32'd1);
      return {c[31:16] & m, c[15:0]};
   endfunction

   task automatic snap();
      b_clk_hi = clk_hi; b_clk_pul = clk_pul; b_in_hi = in_hi;
      b_ld_hi = ld_hi; b_rst_lo = rst_lo; b_act = act;
   endtask

   // entered and left at a negedge; holds cmd_valid until accepted
   task automatic send(input logic [31:0] w);
      int t = 0;
      cmd_data = w;
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
      if (!cmd_ready) chk("send_timeout", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_cap(input logic [31:0] w);
      q_exp.push_back(exp_rd(w));
      send(w);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 3000) begin @(negedge clk); n++; end
      chk("idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic drain();
      logic [31:0] e;
      int t;
      while (q_exp.size() > 0) begin
         t = 0;
         while (!rd_valid && t < 500) begin @(negedge clk); t++; end
         if (!rd_valid) begin
            chk("rd_timeout", {31'd0, rd_valid}, 32'd1);
            q_exp.delete();
            return;
         end
         e = q_exp.pop_front();
         chk("rd_data", rd_data, e);
         rd_ready = 1'b1;
         @(negedge clk);
         rd_ready = 1'b0;
      end
      chk("rd_empty", {31'd0, rd_valid}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, t0, t5, t;
      logic [31:0] c;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_pins", {cclk, cin, cload, crstn}, {4'h0, 4'h0, 4'h0, 4'hF});
      chk("rst_flags", {rd_valid, err, busy, spx}, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // RESET chain 1, clk_div=2, sel=1
      clk_div = 16'd2;
      snap();
      send(32'h0000_0111);
      chk("lat_t1", {31'd0, crstn[1]}, 32'd1);
      @(negedge clk);
      chk("lat_t2", {31'd0, crstn[1]}, 32'd1);
      @(negedge clk);
      chk("lat_t3", {31'd0, crstn[1]}, 32'd0);
      wait_idle(n);
      chk("rst1_low_cycles", rst_lo[1] - b_rst_lo[1], 32'd4);
      chk("rst_others_low", (rst_lo[0] - b_rst_lo[0]) + (rst_lo[2] - b_rst_lo[2]) + (rst_lo[3] - b_rst_lo[3]), 32'd0);
      chk("spx_set", {31'd0, spx}, 32'd1);

      // SHIFT ch0 cnt=7 arg=0x00A5 capture, H=2
      snap();
      send_cap(mk_shift(4'd0, 5'd7, 1'b1, 16'h00A5));
      wait_idle(n);
      chk("sh0_pulses", clk_pul[0] - b_clk_pul[0], 32'd8);
      chk("sh0_hi_cycles", clk_hi[0] - b_clk_hi[0], 32'd16);
      chk("sh0_other_act", (clk_hi[1] - b_clk_hi[1]) + (in_hi[1] - b_in_hi[1]) + (clk_hi[3] - b_clk_hi[3]) + (in_hi[3] - b_in_hi[3]), 32'd0);
      chk("sh0_idle_pins", {cclk, cin}, 8'h00);
      drain();

      // clk_div=0 acts as 1; SHIFT ch2 4 bits, LOAD ch3, SHIFT without capture
      clk_div = 16'd0;
      snap();
      send_cap(mk_shift(4'd2, 5'd3, 1'b1, 16'hFFF6));
      wait_idle(n);
      chk("sh2_pulses", clk_pul[2] - b_clk_pul[2], 32'd4);
      chk("sh2_hi_cycles", clk_hi[2] - b_clk_hi[2], 32'd4);
      snap();
      send(32'h0000_0034);
      wait_idle(n);
      chk("ld3_hi_cycles", ld_hi[3] - b_ld_hi[3], 32'd2);
      chk("ld_others", (ld_hi[0] - b_ld_hi[0]) + (ld_hi[1] - b_ld_hi[1]) + (ld_hi[2] - b_ld_hi[2]), 32'd0);
      send(mk_shift(4'd1, 5'd1, 1'b0, 16'h0003));
      wait_idle(n);
      drain();

      // cnt=31 caps at 16 bits
      clk_div = 16'd1;
      snap();
      send_cap(mk_shift(4'd1, 5'd31, 1'b1, 16'hBEEF));
      wait_idle(n);
      chk("sh1_pulses16", clk_pul[1] - b_clk_pul[1], 32'd16);
      drain();

      // WAIT: arg*2H cycles, arg=0 waits none, no pin activity
      clk_div = 16'd2;
      snap();
      send(32'h0000_0003);
      wait_idle(t0);
      send(32'h0005_0003);
      wait_idle(t5);
      chk("wait_len", t5 - t0, 32'd20);
      chk("wait_no_act", act - b_act, 32'd0);

      // 17 capture SHIFTs queued behind a long WAIT
      clk_div = 16'd1;
      send(32'h0028_0003);
      repeat (2) @(negedge clk);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      cmd_valid = 1'b1;
      for (int k = 0; k < 17; k++) begin
         c = mk_shift(4'(k % 4), 5'd3, 1'b1, 16'h1000 + 16'(k) * 16'h0123);
         cmd_data = c;
         t = 0;
         while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
         chk("burst_accept", {31'd0, cmd_ready}, 32'd1);
         if (k == 16) chk("held17", {31'd0, t > 10}, 32'd1);
         q_exp.push_back(exp_rd(c));
         @(negedge clk);
         if (k == 15) chk("full_after16", {31'd0, cmd_ready}, 32'd0);
      end
      cmd_valid = 1'b0;
      repeat (400) @(negedge clk);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
      drain();
      wait_idle(n);

      // error handling: bad op, bad chain, err_clr priority
      snap();
      send(32'h0000_0007);
      wait_idle(n);
      chk("err_bad_op", {31'd0, err}, 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_cleared", {31'd0, err}, 32'd0);
      send(32'h0000_0052);
      wait_idle(n);
      chk("err_bad_chain", {31'd0, err}, 32'd1);
      chk("err_no_act", act - b_act, 32'd0);
      err_clr = 1'b1;
      send(32'h0000_0044);
      wait_idle(n);
      chk("err_clr_wins", {31'd0, err}, 32'd0);
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_stays_clr", {31'd0, err}, 32'd0);

      // reset mid-SHIFT with a pending readback word and sticky err
      send(mk_shift(4'd0, 5'd0, 1'b1, 16'h0001));
      wait_idle(n);
      chk("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
      send(32'h0000_000F);
      wait_idle(n);
      clk_div = 16'd4;
      send(mk_shift(4'd0, 5'd15, 1'b1, 16'hFFFF));
      t = 0;
      while (!cclk[0] && t < 200) begin @(negedge clk); t++; end
      chk("midsh_clk_seen", {31'd0, cclk[0]}, 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_pins", {cclk, cin, cload, crstn}, {4'h0, 4'h0, 4'h0, 4'hF});
      chk("mid_rst_flags", {rd_valid, err, busy, spx, cmd_ready}, 5'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (50) @(negedge clk);
      chk("mid_rst_quiet", {rd_valid, busy, cclk}, 6'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
